wb_arb_intercon: RTL and testbench
==================================

Name: wb_arb_intercon

Overview:
- Parametrised Wishbone classic interconnect and successor to the single-master decoder used in the marin SoC.
- Arbitrates NUM_MASTERS masters onto one shared bus with a round-robin policy.
- Decodes to NUM_SLAVES slaves by mask/address match.
- Returns a bus error for unmapped addresses and for slaves that fail to respond within TIMEOUT cycles.

Parameters:
- NUM_MASTERS, 2, number of masters (1..4)
- NUM_SLAVES, 4, number of slaves (1..8)
- DATA_WIDTH, 16, data bus width; select width is DATA_WIDTH/8
- ADDR_WIDTH, 32, address width
- SLAVE_MASKS, all zero, packed NUM_SLAVES*ADDR_WIDTH; slice k is the mask for slave k
- SLAVE_ADDRS, all ones, packed NUM_SLAVES*ADDR_WIDTH; slice k is the base address for slave k
- TIMEOUT, 255, maximum cycles a strobe may wait for ack before an error is returned (>=2)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- wbm_dat_i  in  NUM_MASTERS*DATA_WIDTH  master write data (packed, master m at slice m)
- wbm_adr_i  in  NUM_MASTERS*ADDR_WIDTH  master addresses
- wbm_sel_i  in  NUM_MASTERS*DATA_WIDTH/8  master byte selects
- wbm_we_i, wbm_cyc_i, wbm_stb_i  in  NUM_MASTERS  per-master write enable, cycle, strobe
- wbm_dat_o  out  DATA_WIDTH  read data, broadcast to all masters
- wbm_ack_o, wbm_err_o  out  NUM_MASTERS  per-master acknowledge and error
- wbm_gnt_o  out  NUM_MASTERS  one-hot current grant (debug/LEDs)
- wbs_dat_o, wbs_adr_o, wbs_sel_o, wbs_we_o  out  DATA_WIDTH/ADDR_WIDTH/DATA_WIDTH/8/1  shared slave bus, driven from the granted master
- wbs_cyc_o, wbs_stb_o  out  NUM_SLAVES  per-slave cycle and strobe
- wbs_dat_i  in  NUM_SLAVES*DATA_WIDTH  slave read data
- wbs_ack_i  in  NUM_SLAVES  slave acknowledges

Behaviour:
- **Reset** (async, rst_i=1):
  - State = IDLE; grant = 0; last-grant pointer = NUM_MASTERS-1, so master 0 has first priority.
  - Timeout counter = 0.
  - All outputs are 0: ack, err, gnt, slave cyc/stb, shared bus.
- **Reset mid-operation:** all strobes drop immediately; any in-flight slave access is abandoned with no ack and no err.
- **FSM IDLE:**
  - If any wbm_cyc_i is high, grant the first requesting master searching upward (modulo) from last+1.
  - The grant is registered; move to BUSY.
  - No ack/err is produced in IDLE.
- **FSM BUSY:**
  - The shared slave bus mirrors the granted master combinationally.
  - Slave select = lowest index k with (adr & MASK_k) == ADDR_k.
  - wbs_cyc_o[k] = granted cyc & hit; wbs_stb_o[k] = granted stb & hit & ~err_pending.
  - wbm_ack_o[g] = wbs_ack_i[sel] & granted stb; wbm_dat_o = wbs_dat_i[sel] (zero when there is no hit). Ack is zero-latency and combinational.
  - Non-granted masters see ack=0 and err=0.
- **Unmapped address** (stb high, no hit): err_pending is set. wbm_err_o[g] pulses exactly one cycle, on the cycle after the strobe was first seen; it is registered.
- **Timeout:**
  - The counter increments each cycle the granted stb is high with a hit and no ack.
  - It clears on ack, when stb is low, or on grant change.
  - When counter == TIMEOUT-1, err_pending is set: slave stb is deasserted and wbm_err_o[g] is high for one cycle.
  - The counter clears on the err cycle; err_pending clears when the master drops stb.
- **Grant release:**
  - When the granted master's cyc drops, return to IDLE and update last = g.
  - Re-arbitration happens in IDLE on the next cycle, giving one dead cycle between owners.
  - A master holding cyc keeps the bus indefinitely, with no preemption, so locked multi-beat sequences are supported.
- **Simultaneous ack and timeout** on the same cycle: ack wins; no err.
- **Simultaneous requests from all masters:** strict rotation; each master gets exactly one tenure before any master repeats.
- Slave inputs (ack, dat) from unselected slaves are ignored.
- With NUM_MASTERS=1 the block degenerates to a decoder with one cycle of grant latency.

Test Plan:
- **Single read:** reset, then m0 reads 0x1000. SLAVE_MASKS[0]=0xFFFFF000, SLAVE_ADDRS[0]=0x00001000, slave0 acks after 2 cycles with 0xBEEF. Required: gnt=01 one cycle after cyc; wbs_stb_o=0001; wbm_ack_o=01 in the same cycle as the slave ack; wbm_dat_o=0xBEEF.
- **Contention:** m0 and m1 both hold cyc for three transactions each, with release between tenures. Required: grant order m0,m1,m0,m1,m0,m1, with exactly one idle cycle between tenures.
- **Unmapped:** m1 strobes 0x8000_0000 with no matching slave. Required: all wbs_stb_o=0; wbm_err_o[1]=1 for exactly one cycle, one cycle after stb; no ack.
- **Timeout:** TIMEOUT=8; m0 strobes slave0, which never acks. Required: wbs_stb_o[0] high for 7 cycles, then wbm_err_o[0]=1 for one cycle with wbs_stb_o[0]=0 that cycle.
- **Ack at the limit:** slave0 acks on exactly the 7th wait cycle. Required: ack is delivered, err stays 0, and the counter returns to 0.
- **Reset mid-transaction:** assert rst_i asynchronously while m1 holds the bus. Required: gnt=00 and all stb/ack/err=0 immediately; after release, m0 is granted first.

Source files
------------

// File: rtl/wb_arb_intercon.sv
// Wishbone classic interconnect: round-robin arbitration of NUM_MASTERS onto one shared bus,
// mask/address decode to NUM_SLAVES, bus error on unmapped access or slave timeout.
module wb_arb_intercon #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASKS = '0,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_ADDRS = '1,
    parameter int TIMEOUT     = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]            wbm_we_i,
    input  logic [NUM_MASTERS-1:0]            wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]            wbm_stb_i,
    output logic [DATA_WIDTH-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]            wbm_ack_o,
    output logic [NUM_MASTERS-1:0]            wbm_err_o,
    output logic [NUM_MASTERS-1:0]            wbm_gnt_o,
    output logic [DATA_WIDTH-1:0]             wbs_dat_o,
    output logic [ADDR_WIDTH-1:0]             wbs_adr_o,
    output logic [DATA_WIDTH/8-1:0]           wbs_sel_o,
    output logic                              wbs_we_o,
    output logic [NUM_SLAVES-1:0]             wbs_cyc_o,
    output logic [NUM_SLAVES-1:0]             wbs_stb_o,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]             wbs_ack_i
);

    localparam int SW  = DATA_WIDTH / 8;
    localparam int MIW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SIW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW  = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT - 2);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic [MIW-1:0]         r_gidx;
    logic [MIW-1:0]         r_last;
    logic [CW-1:0]          r_cnt;
    logic                   r_err_pend;
    logic                   r_err;

    logic                   w_cyc, w_stb, w_we;
    logic [ADDR_WIDTH-1:0]  w_adr;
    logic [DATA_WIDTH-1:0]  w_dat;
    logic [SW-1:0]          w_sel;
    logic                   w_hit;
    logic [SIW-1:0]         w_sidx;
    logic                   w_sack;
    logic [DATA_WIDTH-1:0]  w_sdat;
    logic                   w_any;
    logic [MIW-1:0]         w_nxt_idx;
    logic [NUM_MASTERS-1:0] w_nxt_oh;

    // Shared bus: AND-OR mux on the one-hot grant, all zero while idle.
    always_comb begin
        w_cyc = 1'b0;
        w_stb = 1'b0;
        w_we  = 1'b0;
        w_adr = '0;
        w_dat = '0;
        w_sel = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (r_gnt[m]) begin
                w_cyc = wbm_cyc_i[m];
                w_stb = wbm_stb_i[m];
                w_we  = wbm_we_i[m];
                w_adr = wbm_adr_i[m*ADDR_WIDTH +: ADDR_WIDTH];
                w_dat = wbm_dat_i[m*DATA_WIDTH +: DATA_WIDTH];
                w_sel = wbm_sel_i[m*SW +: SW];
            end
        end
    end

    // Descending scan so the lowest matching slave index wins.
    always_comb begin
        w_hit  = 1'b0;
        w_sidx = '0;
        if (r_state == BUSY) begin
            for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
                if ((w_adr & SLAVE_MASKS[k*ADDR_WIDTH +: ADDR_WIDTH]) ==
                    SLAVE_ADDRS[k*ADDR_WIDTH +: ADDR_WIDTH]) begin
                    w_hit  = 1'b1;
                    w_sidx = SIW'(k);
                end
            end
        end
    end

    always_comb begin
        w_sack    = 1'b0;
        w_sdat    = '0;
        wbs_cyc_o = '0;
        wbs_stb_o = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (w_hit && (w_sidx == SIW'(k))) begin
                w_sack       = wbs_ack_i[k];
                w_sdat       = wbs_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
                wbs_cyc_o[k] = w_cyc;
                wbs_stb_o[k] = w_stb & ~r_err_pend;
            end
        end
    end

    // Round-robin: search upward from last+1; descending offset leaves the nearest requester.
    always_comb begin
        int idx;
        idx       = 0;
        w_any     = 1'b0;
        w_nxt_idx = r_last;
        w_nxt_oh  = '0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = int'(r_last) + i;
            if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
            if (wbm_cyc_i[idx]) begin
                w_any         = 1'b1;
                w_nxt_idx     = MIW'(idx);
                w_nxt_oh      = '0;
                w_nxt_oh[idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gidx     <= '0;
            r_last     <= MIW'(NUM_MASTERS - 1);
            r_cnt      <= '0;
            r_err_pend <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_err      <= 1'b0;
                    r_err_pend <= 1'b0;
                    r_cnt      <= '0;
                    if (w_any) begin
                        r_gnt   <= w_nxt_oh;
                        r_gidx  <= w_nxt_idx;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_err <= 1'b0;
                    if (!w_cyc) begin
                        r_state    <= IDLE;
                        r_last     <= r_gidx;
                        r_gnt      <= '0;
                        r_cnt      <= '0;
                        r_err_pend <= 1'b0;
                    end else if (!w_stb) begin
                        r_cnt      <= '0;
                        r_err_pend <= 1'b0;
                    end else if (r_err_pend) begin
                        r_cnt <= '0;
                    end else if (!w_hit) begin
                        r_err_pend <= 1'b1;
                        r_err      <= 1'b1;
                        r_cnt      <= '0;
                    end else if (w_sack) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CNT_PRE) begin
                        // Counter reaches TIMEOUT-1 on the error cycle itself.
                        r_cnt      <= CNT_LAST;
                        r_err_pend <= 1'b1;
                        r_err      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign wbm_gnt_o = r_gnt;
    assign wbm_ack_o = r_gnt & {NUM_MASTERS{w_sack & w_stb}};
    assign wbm_err_o = r_gnt & {NUM_MASTERS{r_err}};
    assign wbm_dat_o = w_sdat;
    assign wbs_dat_o = w_dat;
    assign wbs_adr_o = w_adr;
    assign wbs_sel_o = w_sel;
    assign wbs_we_o  = w_we;

endmodule

// File: tb/tb_wb_arb_intercon.sv
// Directed bench for wb_arb_intercon: 2 masters, 4 slaves (two mapped), TIMEOUT=8.
module tb_wb_arb_intercon;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] wbm_dat_i = '0;
    logic [63:0] wbm_adr_i = '0;
    logic [3:0]  wbm_sel_i = '0;
    logic [1:0]  wbm_we_i  = '0;
    logic [1:0]  wbm_cyc_i = '0;
    logic [1:0]  wbm_stb_i = '0;
    logic [15:0] wbm_dat_o;
    logic [1:0]  wbm_ack_o, wbm_err_o, wbm_gnt_o;
    logic [15:0] wbs_dat_o;
    logic [31:0] wbs_adr_o;
    logic [1:0]  wbs_sel_o;
    logic        wbs_we_o;
    logic [3:0]  wbs_cyc_o, wbs_stb_o;
    logic [63:0] wbs_dat_i = '0;
    logic [3:0]  wbs_ack_i = '0;

    int n_chk  = 0;
    int n_fail = 0;

    wb_arb_intercon #(
        .NUM_MASTERS(2), .NUM_SLAVES(4), .DATA_WIDTH(16), .ADDR_WIDTH(32),
        .SLAVE_MASKS({32'h0, 32'h0, 32'hFFFF_F000, 32'hFFFF_F000}),
        .SLAVE_ADDRS({32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_2000, 32'h0000_1000}),
        .TIMEOUT(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .wbm_dat_i(wbm_dat_i), .wbm_adr_i(wbm_adr_i), .wbm_sel_i(wbm_sel_i),
        .wbm_we_i(wbm_we_i), .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
        .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
        .wbm_gnt_o(wbm_gnt_o),
        .wbs_dat_o(wbs_dat_o), .wbs_adr_o(wbs_adr_o), .wbs_sel_o(wbs_sel_o),
        .wbs_we_o(wbs_we_o), .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
        .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setm(input int m, input logic c, input logic s, input logic [31:0] a);
        wbm_cyc_i[m] = c;
        wbm_stb_i[m] = s;
        wbm_adr_i[m*32 +: 32] = a;
    endtask

    // m0 is granted and strobing slave0; expects 7 strobe cycles then a one-cycle err,
    // unless slave0 acks on wait cycle ack_at.
    task automatic tmo_seq(input string tag, input int ack_at);
        for (int j = 0; j < 7; j++) begin
            if (j == ack_at) wbs_ack_i[0] = 1'b1;
            #1;
            chk({tag, "_stb"}, {28'd0, wbs_stb_o}, 32'h1);
            chk({tag, "_noerr"}, {30'd0, wbm_err_o}, 32'h0);
            if (j == ack_at) begin
                chk({tag, "_ack"}, {30'd0, wbm_ack_o}, 32'h1);
                step();
                wbs_ack_i[0] = 1'b0;
                setm(0, 1'b1, 1'b0, 32'h1000);
                #1;
                chk({tag, "_err_after_ack"}, {30'd0, wbm_err_o}, 32'h0);
                return;
            end
            step();
        end
        #1;
        chk({tag, "_err"}, {30'd0, wbm_err_o}, 32'h1);
        chk({tag, "_stb_drop"}, {28'd0, wbs_stb_o}, 32'h0);
        chk({tag, "_cyc_held"}, {28'd0, wbs_cyc_o}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_gnt", {30'd0, wbm_gnt_o}, 32'h0);
        chk("rst_ack", {30'd0, wbm_ack_o}, 32'h0);
        chk("rst_err", {30'd0, wbm_err_o}, 32'h0);
        chk("rst_stb", {28'd0, wbs_stb_o}, 32'h0);
        chk("rst_cyc", {28'd0, wbs_cyc_o}, 32'h0);
        chk("rst_adr", wbs_adr_o, 32'h0);
        #9 rst_i = 1'b0;

        // Single read from slave0
        step();
        setm(0, 1'b1, 1'b1, 32'h1000);
        wbm_dat_i[15:0] = 16'h5A5A;
        wbm_sel_i[1:0]  = 2'b11;
        #1;
        chk("rd_gnt_idle", {30'd0, wbm_gnt_o}, 32'h0);
        step();
        #1;
        chk("rd_gnt", {30'd0, wbm_gnt_o}, 32'h1);
        chk("rd_stb", {28'd0, wbs_stb_o}, 32'h1);
        chk("rd_cyc", {28'd0, wbs_cyc_o}, 32'h1);
        chk("rd_adr", wbs_adr_o, 32'h1000);
        chk("rd_wdat", {16'd0, wbs_dat_o}, 32'h5A5A);
        chk("rd_sel", {30'd0, wbs_sel_o}, 32'h3);
        chk("rd_we", {31'd0, wbs_we_o}, 32'h0);
        chk("rd_ack_w0", {30'd0, wbm_ack_o}, 32'h0);
        step();
        #1;
        chk("rd_ack_w1", {30'd0, wbm_ack_o}, 32'h0);
        step();
        wbs_ack_i[0] = 1'b1;
        wbs_dat_i[15:0] = 16'hBEEF;
        #1;
        chk("rd_ack", {30'd0, wbm_ack_o}, 32'h1);
        chk("rd_dat", {16'd0, wbm_dat_o}, 32'hBEEF);
        step();
        wbs_ack_i[0] = 1'b0;
        setm(0, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rd_ack_off", {30'd0, wbm_ack_o}, 32'h0);
        step();
        #1;
        chk("rd_release", {30'd0, wbm_gnt_o}, 32'h0);

        // Contention: fresh reset so m0 has first priority
        rst_i = 1'b1;
        #3 rst_i = 1'b0;
        wbs_ack_i[1] = 1'b1;
        wbs_dat_i[31:16] = 16'h1234;
        setm(0, 1'b1, 1'b1, 32'h2000);
        setm(1, 1'b1, 1'b1, 32'h2004);
        for (int i = 0; i < 6; i++) begin
            int owner;
            owner = i % 2;
            step();
            #1;
            chk("ct_gnt", {30'd0, wbm_gnt_o}, 32'(1 << owner));
            chk("ct_ack", {30'd0, wbm_ack_o}, 32'(1 << owner));
            chk("ct_dat", {16'd0, wbm_dat_o}, 32'h1234);
            setm(owner, 1'b0, 1'b0, 32'h2000);
            step();
            #1;
            chk("ct_dead", {30'd0, wbm_gnt_o}, 32'h0);
            setm(owner, 1'b1, 1'b1, 32'h2000);
        end
        setm(0, 1'b0, 1'b0, 32'h0);
        setm(1, 1'b0, 1'b0, 32'h0);
        wbs_ack_i[1] = 1'b0;
        step();

        // Unmapped access from m1
        setm(1, 1'b1, 1'b1, 32'h8000_0000);
        step();
        #1;
        chk("um_gnt", {30'd0, wbm_gnt_o}, 32'h2);
        chk("um_stb", {28'd0, wbs_stb_o}, 32'h0);
        chk("um_err0", {30'd0, wbm_err_o}, 32'h0);
        chk("um_dat", {16'd0, wbm_dat_o}, 32'h0);
        step();
        #1;
        chk("um_err", {30'd0, wbm_err_o}, 32'h2);
        chk("um_stb1", {28'd0, wbs_stb_o}, 32'h0);
        chk("um_ack", {30'd0, wbm_ack_o}, 32'h0);
        step();
        #1;
        chk("um_err_end", {30'd0, wbm_err_o}, 32'h0);
        setm(1, 1'b0, 1'b0, 32'h0);
        step();
        step();

        // Timeout, ack at the limit, then a full timeout again
        setm(0, 1'b1, 1'b1, 32'h1000);
        step();
        chk("to_gnt", {30'd0, wbm_gnt_o}, 32'h1);
        tmo_seq("tmo", -1);
        step();
        #1;
        chk("tmo_err_end", {30'd0, wbm_err_o}, 32'h0);
        chk("tmo_stb_hold", {28'd0, wbs_stb_o}, 32'h0);
        setm(0, 1'b1, 1'b0, 32'h1000);
        step();
        setm(0, 1'b1, 1'b1, 32'h1000);
        tmo_seq("ackl", 6);
        step();
        setm(0, 1'b1, 1'b1, 32'h1000);
        tmo_seq("tmo2", -1);
        setm(0, 1'b0, 1'b0, 32'h0);
        step();
        step();

        // Asynchronous reset while m1 owns the bus
        setm(1, 1'b1, 1'b1, 32'h2000);
        step();
        #1;
        chk("mr_gnt", {30'd0, wbm_gnt_o}, 32'h2);
        chk("mr_stb", {28'd0, wbs_stb_o}, 32'h2);
        #2 rst_i = 1'b1;
        setm(0, 1'b1, 1'b1, 32'h1000);
        #1;
        chk("mr_rst_gnt", {30'd0, wbm_gnt_o}, 32'h0);
        chk("mr_rst_stb", {28'd0, wbs_stb_o}, 32'h0);
        chk("mr_rst_cyc", {28'd0, wbs_cyc_o}, 32'h0);
        chk("mr_rst_ack", {30'd0, wbm_ack_o}, 32'h0);
        chk("mr_rst_err", {30'd0, wbm_err_o}, 32'h0);
        chk("mr_rst_adr", wbs_adr_o, 32'h0);
        #2 rst_i = 1'b0;
        step();
        chk("mr_first", {30'd0, wbm_gnt_o}, 32'h1);
        chk("mr_first_stb", {28'd0, wbs_stb_o}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
